ram_responder: RTL
==================

# ram_responder

Memory-side responder for the SPARC V8 load/store path. It accepts one request at a time from the control unit's `RAM_enable` / `RAM_OpCode` strobe, with address and write data taken from MAR/MDR. It performs a byte-addressed big-endian access after a fixed latency and signals completion with `MFC`, holding it until the initiator drops its request. It sits between the MAR/MDR registers and the MDR input mux, replacing the combinational RAM model.

## Interface
Parameters:
- `ADDR_WIDTH`, default 9. Byte-address width; memory depth is 2^ADDR_WIDTH bytes.
- `LATENCY`, default 2. Cycles from request acceptance to `MFC` assertion. Legal range is 1..15.

Ports:
- `Clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `Clr`: input, 1 bit. Reset, synchronous and active-low.
- `RAM_enable`: input, 1 bit. Request strobe from the control unit; held high until `MFC` is observed.
- `RAM_OpCode`: input, 6 bits. SPARC op3 field of the load/store.
- `Address`: input, 32 bits. MAR output; only bits `[ADDR_WIDTH-1:0]` are used.
- `DataIn`: input, 32 bits. MDR output; store data, right-justified for byte and halfword.
- `MFC`: output, 1 bit. Memory function complete.
- `DataOut`: output, 32 bits. Load result, extended to 32 bits; valid while `MFC` is high.
- `Err`: output, 1 bit. Request was illegal or misaligned; valid while `MFC` is high.

## Operation
- Opcodes:
  - `000000` LD: word load.
  - `000001` LDUB: byte load, zero-extended.
  - `000010` LDUH: halfword load, zero-extended.
  - `001001` LDSB: byte load, sign-extended.
  - `001010` LDSH: halfword load, sign-extended.
  - `000100` ST: word store.
  - `000101` STB: byte store.
  - `000110` STH: halfword store.
  - Any other opcode: `Err`=1, no write, `DataOut`=0.
- Byte order is big-endian: address A holds bits `[31:24]` of a word, and A+3 holds bits `[7:0]`.
- State machine:
  - IDLE: `MFC`=0. A `RAM_enable`=1 sample latches opcode, address and data, loads the counter with LATENCY-1, and moves to BUSY.
  - BUSY: the counter decrements each cycle. At 0, the access is performed (read captured into `DataOut`, store committed to the array) and the state moves to DONE.
  - DONE: `MFC`=1, and `DataOut`/`Err` are held stable. While `RAM_enable`=0 is sampled, the state returns to IDLE.
- Inputs are sampled only in IDLE. Changes to `Address`, `DataIn` or `RAM_OpCode` during BUSY or DONE have no effect.
- `RAM_enable` dropping during BUSY does not abort the access. The access completes, DONE is entered, and the state leaves DONE on the next cycle because enable is already low.
- Address wrap: byte offsets +1..+3 are computed modulo 2^ADDR_WIDTH.

## Timing
- Request sampled at edge N. The access is performed at edge N+LATENCY, and `MFC` is high after edge N+LATENCY.
- Handshake is a four-phase level handshake. `MFC` falls one cycle after `RAM_enable`=0 is sampled in DONE. The earliest next request is sampled one cycle after that, in IDLE.
- Back-to-back requests are not accepted: an enable still high in the first IDLE cycle after DONE is treated as a new request. The initiator must drop enable after seeing `MFC`.
- Reset values: `MFC`=0, `DataOut`=0, `Err`=0, state=IDLE, counter=0.
- Reset mid-operation: return to IDLE with outputs at reset values. A store that has not yet reached its perform edge is discarded. Array contents are never cleared by `Clr`.
- Reset asserted on the perform edge wins: nothing is written.

## Configuration
- `RAM_MISALIGN_TRAP_EN` defined: a halfword access with `Address[0]`=1, or a word access with `Address[1:0]`≠0, completes normally with `Err`=1, no write, and `DataOut`=0.
- `RAM_MISALIGN_TRAP_EN` undefined: the low address bits are forced to alignment, the access proceeds, and `Err` reflects illegal opcodes only.

## Structure
- A shared package `sparc_mem_pkg` holds:
  - the op3 localparams for the eight opcodes;
  - the access-size enum (byte, half, word);
  - the state enum (IDLE, BUSY, DONE).
- Sub-module `ram_byte_array`: a synchronous byte-wide array with four byte-lane write enables and a 32-bit big-endian read port. The responder holds only the FSM, counter, decode, and extend/merge logic.

## Test plan
- Preload bytes 8..11 = `FF 00 80 7F`. LD at 8 with LATENCY=2: `MFC` rises 2 cycles after acceptance, `DataOut`=`32'hFF00807F`, `Err`=0.
- Same preload:
  - LDSB at 10 returns `32'hFFFFFF80`.
  - LDUB at 10 returns `32'h00000080`.
  - LDSH at 10 returns `32'hFFFF807F`.
- STB at 9 with data `32'h000000AB`, then LD at 8: `32'hFF AB 80 7F`, with bytes 8, 10 and 11 unchanged.
- ST at 4 with `Clr` pulsed low in BUSY: `MFC` stays 0, then a LD at 4 returns the prior contents.
- Hold `RAM_enable` high for 5 cycles after `MFC`: `MFC` and `DataOut` stay stable. Drop enable: `MFC`=0 one cycle later.
- LDUH at 9:
  - with `RAM_MISALIGN_TRAP_EN`: `Err`=1 and `DataOut`=0;
  - without it: `Err`=0 and `DataOut`=`32'h0000FF00` (access aligned to 8).
- Opcode `111111`: `Err`=1 and memory unchanged.

Source files
------------

// File: rtl/sparc_mem_pkg.sv
// Shared op3 codes, access sizes and FSM states for the
// SPARC memory responder.
package sparc_mem_pkg;

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  typedef struct packed {
    logic  legal;
    logic  store;
    logic  sext;
    size_e size;
  } op_dec_t;

  function automatic op_dec_t decode_op(
    input logic [5:0] op
  );
    op_dec_t d;
    d = '{legal: 1'b1, store: 1'b0,
          sext: 1'b0, size: SZ_WORD};
    unique case (1'b1)
      (op == OP_LD):   d.size = SZ_WORD;
      (op == OP_LDUB): d.size = SZ_BYTE;
      (op == OP_LDUH): d.size = SZ_HALF;
      (op == OP_LDSB): begin
        d.size = SZ_BYTE;
        d.sext = 1'b1;
      end
      (op == OP_LDSH): begin
        d.size = SZ_HALF;
        d.sext = 1'b1;
      end
      (op == OP_ST): d.store = 1'b1;
      (op == OP_STB): begin
        d.size  = SZ_BYTE;
        d.store = 1'b1;
      end
      (op == OP_STH): begin
        d.size  = SZ_HALF;
        d.store = 1'b1;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ram_byte_array.sv
// Byte-wide storage with four lane write enables and a
// big-endian 32-bit read port starting at addr (wrapping).
module ram_byte_array #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [7:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] lane_addr [4];

  // lane i is byte addr+i, carried in bits [31-8i -: 8]
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = addr + ADDR_WIDTH'(i);
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      rdata[31-8*i -: 8] = mem[lane_addr[i]];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[3-i]) begin
        mem[lane_addr[i]] <= wdata[31-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/ram_responder.sv
// Fixed-latency big-endian RAM responder with MFC handshake.
// Optional macro: RAM_MISALIGN_TRAP_EN (misaligned access -> Err).
module ram_responder
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int LATENCY    = 2
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        RAM_enable,
  input  logic [5:0]  RAM_OpCode,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic        MFC,
  output logic [31:0] DataOut,
  output logic        Err
);

  localparam int AW = ADDR_WIDTH;

  state_e state;
  state_e state_nx;

  logic [3:0]    cnt;
  logic [5:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;

  op_dec_t       dec;
  logic          perform;
  logic          misaligned;
  logic          req_err;
  logic [AW-1:0] eff_addr;
  logic [3:0]    we;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [31:0]   ld_val;
  logic          unused_addr;

  assign unused_addr = ^Address[31:AW];
  assign dec = decode_op(op_q);

  always_ff @(posedge Clk) begin
    if (!Clr) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (RAM_enable) state_nx = S_BUSY;
      S_BUSY: if (cnt == 4'd0) state_nx = S_DONE;
      S_DONE: if (!RAM_enable) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    MFC     = (state == S_DONE);
    perform = (state == S_BUSY) && (cnt == 4'd0);
  end

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      cnt    <= '0;
      op_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (state == S_IDLE) begin
      if (RAM_enable) begin
        cnt    <= 4'(LATENCY - 1);
        op_q   <= RAM_OpCode;
        addr_q <= Address[AW-1:0];
        data_q <= DataIn;
      end
    end else if (state == S_BUSY) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end

`ifdef RAM_MISALIGN_TRAP_EN
  always_comb begin
    eff_addr   = addr_q;
    misaligned = ((dec.size == SZ_HALF) && addr_q[0]) ||
                 ((dec.size == SZ_WORD) &&
                  (addr_q[1:0] != 2'b00));
  end
`else
  always_comb begin
    misaligned = 1'b0;
    eff_addr   = addr_q;
    unique case (dec.size)
      SZ_HALF: eff_addr[0]   = 1'b0;
      SZ_WORD: eff_addr[1:0] = 2'b00;
      default: eff_addr      = addr_q;
    endcase
  end
`endif

  assign req_err = !dec.legal || misaligned;

  // Clr gates the write so reset on the perform edge wins
  always_comb begin
    we    = '0;
    wdata = data_q;
    unique case (dec.size)
      SZ_BYTE: begin
        we    = 4'b1000;
        wdata = {data_q[7:0], 24'h0};
      end
      SZ_HALF: begin
        we    = 4'b1100;
        wdata = {data_q[15:0], 16'h0};
      end
      default: we = 4'b1111;
    endcase
    if (!(perform && Clr && dec.store && !req_err)) begin
      we = '0;
    end
  end

  always_comb begin
    ld_val = rdata;
    unique case (dec.size)
      SZ_BYTE: ld_val = {{24{dec.sext & rdata[31]}},
                         rdata[31:24]};
      SZ_HALF: ld_val = {{16{dec.sext & rdata[31]}},
                         rdata[31:16]};
      default: ld_val = rdata;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      DataOut <= '0;
      Err     <= 1'b0;
    end else if (perform) begin
      Err     <= req_err;
      DataOut <= (req_err || dec.store) ? '0 : ld_val;
    end
  end

  ram_byte_array #(
    .ADDR_WIDTH(AW)
  ) u_array (
    .clk  (Clk),
    .we   (we),
    .addr (eff_addr),
    .wdata(wdata),
    .rdata(rdata)
  );

endmodule
